adder_bist: RTL and testbench

Built-in self-test driver and checker for the lab adder. The lab adder computes z = x + y for WIDTH-bit operands. This block sits on the other side of that interface: it drives every (x, y) operand pair into the adder, waits for the result to settle, and compares z against its own reference sum. It counts mismatches and reports pass/fail, replacing the manual testbench stimulus when the design runs on the board.

---
 rtl/adder_bist_if.sv | 25 ++
 rtl/adder_bist.sv | 84 ++++++++
 tb/tb_adder_bist.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_if.sv
// adder_bist_if: operand/result and status bundle between adder_bist and the adder under test.
interface adder_bist_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   z;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_count;
    logic [WIDTH-1:0] fail_x;
    logic [WIDTH-1:0] fail_y;

    modport master (
        input  start, z,
        output x, y, busy, done, pass, err_count, fail_x, fail_y
    );

    modport slave (
        output start, z,
        input  x, y, busy, done, pass, err_count, fail_x, fail_y
    );
endinterface

// File: rtl/adder_bist.sv
// adder_bist: exhaustive sweep driver and checker for a WIDTH-bit adder (z = x + y).
// Define ADDER_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module adder_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input logic          clk,
    input logic          rst,
    adder_bist_if.master bus
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mism;
    logic          last;
    logic          stop;
    logic [7:0]    err_inc;

    assign mism    = bus.z != ({1'b0, bus.x} + {1'b0, bus.y});
    assign last    = &{bus.x, bus.y};
    assign err_inc = (bus.err_count == 8'hff) ? bus.err_count : bus.err_count + 8'd1;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign stop = last || mism;
`else
    assign stop = last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.x         <= '0;
            bus.y         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.fail_x    <= '0;
            bus.fail_y    <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state         <= APPLY;
                    cnt           <= '0;
                    bus.x         <= '0;
                    bus.y         <= '0;
                    bus.busy      <= 1'b1;
                    bus.done      <= 1'b0;
                    bus.pass      <= 1'b0;
                    bus.err_count <= '0;
                    bus.fail_x    <= '0;
                    bus.fail_y    <= '0;
                end
                APPLY: begin
                    state <= (cnt == CW'(SETTLE - 1)) ? CHECK : APPLY;
                    cnt   <= (cnt == CW'(SETTLE - 1)) ? '0 : cnt + CW'(1);
                end
                CHECK: begin
                    if (mism) begin
                        bus.err_count <= err_inc;
                    end
                    // err_count never returns to zero mid-sweep, so zero marks the first miss
                    if (mism && bus.err_count == 8'd0) begin
                        bus.fail_x <= bus.x;
                        bus.fail_y <= bus.y;
                    end
                    if (stop) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= !mism && bus.err_count == 8'd0;
                    end else begin
                        state            <= APPLY;
                        {bus.x, bus.y}   <= {bus.x, bus.y} + (2 * WIDTH)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: drives adder_bist against good and faulty adder models; a scoreboard holds the expected sweep results.
module tb_adder_bist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    int         vectors = 0;
    int         miscompares = 0;

    typedef struct {
        int         cyc;
        logic [7:0] err;
        logic       pass;
        logic [3:0] fx;
        logic [3:0] fy;
        logic [3:0] ex;
        logic [3:0] ey;
    } exp_t;

    exp_t sb[$];

    adder_bist_if #(.WIDTH(4)) bus ();

    adder_bist #(.WIDTH(4), .SETTLE(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // adder models: 0 correct, 1 carry-out stuck at 0, 2 off by one
    assign bus.z = (mode == 2'd0) ? {1'b0, bus.x} + {1'b0, bus.y} :
                   (mode == 2'd1) ? {1'b0, 4'(bus.x + bus.y)} :
                                    {1'b0, bus.x} + {1'b0, bus.y} + 5'd1;

    task automatic push(input int cyc, input logic [7:0] err, input logic pass,
                        input logic [3:0] fx, input logic [3:0] fy,
                        input logic [3:0] ex, input logic [3:0] ey);
        exp_t e;
        e.cyc = cyc; e.err = err; e.pass = pass;
        e.fx = fx; e.fy = fy; e.ex = ex; e.ey = ey;
        sb.push_back(e);
    endtask

    // Pulses start, optionally re-pulses it at edge 'extra', and checks the result against the scoreboard.
    task automatic run_sweep(input int extra);
        exp_t e;
        int   n;
        logic found;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1)
            begin miscompares++; $display("FAIL start_ack: done=%b busy=%b, need done=0 busy=1", bus.done, bus.busy); end
        n = 0;
        found = 1'b0;
        while (!found && n < 1000) begin
            if (bus.done === 1'b1) begin
                found = 1'b1;
            end else begin
                if (mode == 2'd0 && n < 768) begin
                    vectors++;
                    if ({bus.x, bus.y} !== 8'(n / 3) || bus.busy !== 1'b1)
                        begin miscompares++; $display("FAIL operands@%0d: x=%0d y=%0d busy=%b, need x=%0d y=%0d busy=1", n, bus.x, bus.y, bus.busy, (n / 3) / 16, (n / 3) % 16); end
                end
                bus.start = (extra != 0 && n + 1 == extra);
                @(posedge clk);
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++; $display("FAIL scoreboard: empty queue, need an expectation");
        end else begin
            e = sb.pop_front();
            if (!found) begin
                miscompares++; $display("FAIL done_timeout: no done within 1000 cycles, need done at cycle %0d", e.cyc);
            end else begin
                if (n + 1 !== e.cyc)
                    begin miscompares++; $display("FAIL done_cycle: got %0d, need %0d", n + 1, e.cyc); end
                vectors++;
                if (bus.err_count !== e.err)
                    begin miscompares++; $display("FAIL err_count: got %0d, need %0d", bus.err_count, e.err); end
                vectors++;
                if (bus.pass !== e.pass || bus.busy !== 1'b0)
                    begin miscompares++; $display("FAIL pass_busy: pass=%b busy=%b, need pass=%b busy=0", bus.pass, bus.busy, e.pass); end
                vectors++;
                if (bus.fail_x !== e.fx || bus.fail_y !== e.fy)
                    begin miscompares++; $display("FAIL fail_xy: got %0d,%0d need %0d,%0d", bus.fail_x, bus.fail_y, e.fx, e.fy); end
                vectors++;
                if (bus.x !== e.ex || bus.y !== e.ey)
                    begin miscompares++; $display("FAIL final_xy: got %0d,%0d need %0d,%0d", bus.x, bus.y, e.ex, e.ey); end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.x !== 4'd0 || bus.y !== 4'd0)
            begin miscompares++; $display("FAIL reset_xy: x=%0d y=%0d, need 0,0", bus.x, bus.y); end
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0)
            begin miscompares++; $display("FAIL reset_flags: busy=%b done=%b pass=%b, need 0,0,0", bus.busy, bus.done, bus.pass); end
        vectors++;
        if (bus.err_count !== 8'd0 || bus.fail_x !== 4'd0 || bus.fail_y !== 4'd0)
            begin miscompares++; $display("FAIL reset_err: err=%0d fx=%0d fy=%0d, need 0,0,0", bus.err_count, bus.fail_x, bus.fail_y); end
        rst = 1'b0;
    endtask

    task automatic test_sweep;
        mode = 2'd0;
        push(769, 8'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15);
        run_sweep(0);
    endtask

    task automatic test_stuck_carry;
        mode = 2'd1;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        push(97, 8'd1, 1'b0, 4'd1, 4'd15, 4'd1, 4'd15);
`else
        push(769, 8'd120, 1'b0, 4'd1, 4'd15, 4'd15, 4'd15);
`endif
        run_sweep(0);
    endtask

    task automatic test_saturate;
        mode = 2'd2;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        push(4, 8'd1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
`else
        push(769, 8'd255, 1'b0, 4'd0, 4'd0, 4'd15, 4'd15);
`endif
        run_sweep(0);
    endtask

    task automatic test_reset_mid;
        mode = 2'd2;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        repeat (299) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.err_count === 8'd0)
            begin miscompares++; $display("FAIL mid_sweep: busy=%b err=%0d, need busy=1 err>0", bus.busy, bus.err_count); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.x, bus.y, bus.fail_x, bus.fail_y} !== 16'd0 || bus.err_count !== 8'd0)
            begin miscompares++; $display("FAIL mid_reset_data: x=%0d y=%0d fx=%0d fy=%0d err=%0d, need all 0", bus.x, bus.y, bus.fail_x, bus.fail_y, bus.err_count); end
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0)
            begin miscompares++; $display("FAIL mid_reset_flags: busy=%b done=%b pass=%b, need 0,0,0", bus.busy, bus.done, bus.pass); end
        rst = 1'b0;
        mode = 2'd0;
        push(769, 8'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15);
        run_sweep(0);
    endtask

    task automatic test_back_to_back;
        mode = 2'd0;
        push(769, 8'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15);
        run_sweep(50);
        repeat (31) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1)
            begin miscompares++; $display("FAIL done_hold: done=%b pass=%b, need 1,1", bus.done, bus.pass); end
        push(769, 8'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15);
        run_sweep(0);
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset;
        test_sweep;
        test_stuck_carry;
        test_saturate;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
